activation_eval: RTL and testbench
==================================

# activation_eval

Multi-cycle evaluator for the neuron activation function. It takes a signed Q8.24 pre-activation, selects a piecewise segment from |x|, and computes the quadratic c2·|x|² + c1·|x| + c0 in Horner form on one shared multiplier. Negative inputs are mirrored as f(−x) = 1.0 − f(x). It sits between the neuron accumulator and the layer output register, behind a valid/ready handshake on each side.

## Interface
- DWIDTH, 32, data width: Q8.24 signed, 8 integer bits including sign.
- FRAC, 24, fractional bits: 1.0 = 0x01000000.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept; high only in IDLE and not in reset
- in_data  in  DWIDTH  pre-activation x, signed Q8.24
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DWIDTH  f(x), Q8.24, always in range 0 to 0x01000000

## Operation
- FSM states: IDLE → SEL → MUL1 → MUL2 → FIX → OUT → IDLE.
- IDLE: on in_valid & in_ready, register x and neg = x[31], then go to SEL.
- SEL: register ax = |x|.
  - x = 0x80000000 saturates to 0x7FFFFFFF.
  - seg = 6 if ax[31:24] ≥ 6, else ax[26:24].
  - Register c0, c1, c2 from the segment tables; seg 5 uses the seg 4 entries; seg 6 is saturation (c0 = 1.0, c1 = c2 = 0).
- MUL1: acc ← ((c2 · ax) >>> FRAC) + c1.
- MUL2: acc ← ((acc · ax) >>> FRAC) + c0.
- Arithmetic rules:
  - Multiplies are signed 32×32 → 64.
  - The result keeps product bits [55:24], i.e. an arithmetic shift that truncates toward −∞.
  - Adds are 32-bit wrapping; no overflow can occur for ax < 6.0.
- FIX: y = neg ? (0x01000000 − acc) : acc, clamped to 0…0x01000000. Register y into out_data and set out_valid.
- OUT: hold out_data and out_valid stable until out_ready; on out_valid & out_ready, clear out_valid and go to IDLE.
- One multiplier instance is shared by MUL1 and MUL2.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, acc/x/coefficients 0. in_ready is 0 while rst is high and 1 on the first cycle after rst deasserts.
- Latency: the accepting edge E moves the FSM to SEL. out_valid is first high after edge E+4.
- Throughput: at most one result per 6 cycles with out_ready held high. in_ready is low from the accepting edge until the OUT→IDLE edge.
- in_valid while busy is ignored; the upstream must hold it, per the handshake.
- Backpressure: out_ready low holds OUT indefinitely, and out_data must not change.
- Reset mid-operation: rst in any state returns to IDLE on that edge, drops out_valid, and discards the in-flight sample.
- Simultaneous out_ready and in_valid in OUT: the result completes, and the new input is not accepted until the next cycle, which is IDLE.

## Structure
- Package activation_pkg holds DWIDTH, FRAC, ONE = 0x01000000, the state enum, and the coefficient constants by segment 0..4:
  - c0: 00800000, 00D14000, 00EC8000, 00F84000, 00FE4000
  - c1: 00400000, 00260000, 0011C000, 00074000, 00018000
  - c2: 00000000, FFF40000, FFF88000, FFFCC000, FFFF4000
  - Saturation row: c0 = ONE, c1 = c2 = 0.
- One sub-module, activation_coef_rom: combinational, seg[2:0] → {c0, c1, c2}, reading package constants.
- Multiplier, FSM and datapath stay in activation_eval.

## Test plan
- x = 0x00000000 → out_data 0x00800000, with out_valid rising exactly 4 edges after acceptance.
- x = 0x00800000 (0.5) → 0x00A00000; x = 0xFF800000 (−0.5) → 0x00600000.
- x = 0x01000000 (1.0, seg 1) → 0x00EB4000; x = 0xFF000000 → 0x0014C000.
- Saturation inputs:
  - x = 0x07000000 → 0x01000000.
  - x = 0x80000000 → 0x00000000.
  - x = 0x7FFFFFFF → 0x01000000.
- Backpressure: hold out_ready low 10 cycles with in_valid high → out_data stable, in_ready 0, no second accept. Release → exactly one handshake, IDLE next cycle.
- Assert rst during MUL1 → next cycle out_valid 0, in_ready 1. A new x = 0x00800000 then yields 0x00A00000 with normal latency.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared constants, state encoding, coefficient tables and segment select
// for the piecewise-quadratic activation evaluator.
package activation_pkg;

  localparam int          DWIDTH = 32;
  localparam int          FRAC   = 24;
  localparam logic [31:0] ONE    = 32'h0100_0000;
  localparam logic [31:0] XMIN   = 32'h8000_0000;
  localparam logic [31:0] XMAX   = 32'h7FFF_FFFF;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_SEL  = 3'd1;
  localparam state_t S_MUL1 = 3'd2;
  localparam state_t S_MUL2 = 3'd3;
  localparam state_t S_FIX  = 3'd4;
  localparam state_t S_OUT  = 3'd5;

  localparam logic [2:0] SAT_SEG = 3'd6;

  typedef struct packed {
    logic [DWIDTH-1:0] c0;
    logic [DWIDTH-1:0] c1;
    logic [DWIDTH-1:0] c2;
  } coef_t;

  localparam logic [0:4][31:0] C0_TAB = '{32'h0080_0000, 32'h00D1_4000, 32'h00EC_8000,
                                          32'h00F8_4000, 32'h00FE_4000};
  localparam logic [0:4][31:0] C1_TAB = '{32'h0040_0000, 32'h0026_0000, 32'h0011_C000,
                                          32'h0007_4000, 32'h0001_8000};
  localparam logic [0:4][31:0] C2_TAB = '{32'h0000_0000, 32'hFFF4_0000, 32'hFFF8_8000,
                                          32'hFFFC_C000, 32'hFFFF_4000};

  // |x| >= 6.0 saturates; below that the integer part picks the segment.
  function automatic logic [2:0] seg_sel(input logic [31:0] ax);
    if (ax[31:24] >= 8'd6) return SAT_SEG;
    return ax[26:24];
  endfunction

endpackage

// File: rtl/activation_coef_rom.sv
// Segment index to quadratic coefficients; seg 5 reuses seg 4, seg 6/7 saturate.
module activation_coef_rom
  import activation_pkg::*;
(
  input  logic [2:0] seg_i,
  output coef_t      coef_o
);

  always_comb begin
    coef_o = '{c0: ONE, c1: '0, c2: '0};
    case (seg_i)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4:
        coef_o = '{c0: C0_TAB[seg_i], c1: C1_TAB[seg_i], c2: C2_TAB[seg_i]};
      3'd5:
        coef_o = '{c0: C0_TAB[4], c1: C1_TAB[4], c2: C2_TAB[4]};
      default: ;
    endcase
  end

endmodule

// File: rtl/activation_eval.sv
// Multi-cycle activation evaluator: |x| segment select, Horner quadratic on
// one shared multiplier, mirror for negative x, clamp to [0, 1.0].
module activation_eval
  import activation_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data
);

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] x_q, x_d;
  logic              neg_q, neg_d;
  logic [DWIDTH-1:0] ax_q, ax_d;
  coef_t             coef_q, coef_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [DWIDTH-1:0] ax_abs;
  logic [2:0]        seg;
  coef_t             rom_coef;

  // Most-negative input has no positive twin; pin it to the largest magnitude.
  always_comb begin
    ax_abs = x_q;
    if (x_q == XMIN)  ax_abs = XMAX;
    else if (x_q[31]) ax_abs = -x_q;
  end

  assign seg = seg_sel(ax_abs);

  activation_coef_rom u_rom (
    .seg_i  (seg),
    .coef_o (rom_coef)
  );

  logic [DWIDTH-1:0]   mul_a, mul_add, horner;
  logic signed [63:0]  prod;
  logic                unused_prod_bits;

  assign mul_a   = (state_q == S_MUL1) ? coef_q.c2 : acc_q;
  assign mul_add = (state_q == S_MUL1) ? coef_q.c1 : coef_q.c0;
  assign prod    = $signed(mul_a) * $signed(ax_q);
  assign horner  = prod[FRAC+DWIDTH-1:FRAC] + mul_add;
  assign unused_prod_bits = ^{prod[63:FRAC+DWIDTH], prod[FRAC-1:0]};

  logic [DWIDTH-1:0] y_raw, y_clamp;

  always_comb begin
    y_raw   = neg_q ? (ONE - acc_q) : acc_q;
    y_clamp = y_raw;
    if (y_raw[DWIDTH-1])                   y_clamp = '0;
    else if ($signed(y_raw) > $signed(ONE)) y_clamp = ONE;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    neg_d       = neg_q;
    ax_d        = ax_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        x_d     = in_data;
        neg_d   = in_data[DWIDTH-1];
        state_d = S_SEL;
      end
      S_SEL: begin
        ax_d    = ax_abs;
        coef_d  = rom_coef;
        state_d = S_MUL1;
      end
      S_MUL1: begin
        acc_d   = horner;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        acc_d   = horner;
        state_d = S_FIX;
      end
      S_FIX: begin
        out_data_d  = y_clamp;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      neg_q       <= 1'b0;
      ax_q        <= '0;
      coef_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      neg_q       <= neg_d;
      ax_q        <= ax_d;
      coef_q      <= coef_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_activation_eval.sv
// Self-checking bench: directed table, handshake corner sequences and a
// randomized run against an arithmetic reference model.
module tb_activation_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int nvec = 0;
  int nerr = 0;
  int hs   = 0;

  activation_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready) hs++;

  localparam longint M_ONE = 64'sd16777216;

  function automatic longint fdiv(input longint p);
    longint q;
    q = p / M_ONE;
    if (p < 0 && q * M_ONE != p) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x);
    int     c0m [5] = '{32'h0080_0000, 32'h00D1_4000, 32'h00EC_8000, 32'h00F8_4000, 32'h00FE_4000};
    int     c1m [5] = '{32'h0040_0000, 32'h0026_0000, 32'h0011_C000, 32'h0007_4000, 32'h0001_8000};
    int     c2m [5] = '{32'h0000_0000, 32'hFFF4_0000, 32'hFFF8_8000, 32'hFFFC_C000, 32'hFFFF_4000};
    longint sx, ax, f, y;
    int     s;
    logic [63:0] yb;
    sx = longint'($signed(x));
    ax = (sx < 0) ? -sx : sx;
    if (ax > 64'sd2147483647) ax = 64'sd2147483647;
    if (ax >= 6 * M_ONE) f = M_ONE;
    else begin
      s = int'(ax / M_ONE);
      if (s == 5) s = 4;
      f = fdiv(longint'(c2m[s]) * ax) + longint'(c1m[s]);
      f = fdiv(f * ax) + longint'(c0m[s]);
    end
    y = (sx < 0) ? (M_ONE - f) : f;
    if (y < 0) y = 0;
    if (y > M_ONE) y = M_ONE;
    yb = y;
    return yb[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [31:0] x);
    int g = 0;
    while (!in_ready && g < 20) begin tick(); g++; end
    if (g >= 20) chk("accept timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; waits for result and completes handshake.
  task automatic finish_one(input logic [31:0] exp, input string name, input int delay);
    int lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({name, " latency"}, lat, 32'd4);
    chk(name, out_data, exp);
    if (delay > 0) begin
      repeat (delay) tick();
      chk({name, " hold"}, {out_data[31:1], out_data[0] & out_valid}, {exp[31:1], exp[0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " done"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  initial begin
    vec_t tab [8];
    logic [31:0] x, bp_data;
    int          bp_ok, hs0;
    tab[0] = '{32'h0000_0000, 32'h0080_0000};
    tab[1] = '{32'h0080_0000, 32'h00A0_0000};
    tab[2] = '{32'hFF80_0000, 32'h0060_0000};
    tab[3] = '{32'h0100_0000, 32'h00EB_4000};
    tab[4] = '{32'hFF00_0000, 32'h0014_C000};
    tab[5] = '{32'h0700_0000, 32'h0100_0000};
    tab[6] = '{32'h8000_0000, 32'h0000_0000};
    tab[7] = '{32'h7FFF_FFFF, 32'h0100_0000};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset in_ready",  {31'd0, in_ready},  32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data",  out_data,           32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      accept(tab[i].x);
      chk($sformatf("busy %0d", i), {31'd0, in_ready}, 32'd0);
      finish_one(tab[i].y, $sformatf("table %h", tab[i].x), i % 3);
    end

    // Backpressure with in_valid held high throughout.
    in_valid = 1'b1; in_data = 32'h0080_0000;
    tick();
    begin
      int lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk("bp latency", lat, 32'd4);
    end
    bp_data = out_data;
    chk("bp data", bp_data, 32'h00A0_0000);
    bp_ok = 1;
    repeat (10) begin
      tick();
      if (!out_valid || out_data !== bp_data || in_ready) bp_ok = 0;
    end
    chk("bp stable", bp_ok, 32'd1);
    hs0 = hs;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp one handshake", hs - hs0, 32'd1);
    chk("bp release idle", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp reaccept", {31'd0, in_ready}, 32'd0);
    finish_one(32'h00A0_0000, "bp second", 0);

    // Reset while in MUL1 drops the sample.
    accept(32'h0100_0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst mul1", {30'd0, out_valid, in_ready}, 32'd1);
    accept(32'h0080_0000);
    finish_one(32'h00A0_0000, "after rst", 0);

    for (int i = 0; i < 150; i++) begin
      if (i % 4 == 0) x = $urandom;
      else            x = $urandom_range(0, 32'h0FFF_FFFF) - 32'h0800_0000;
      accept(x);
      finish_one(model(x), $sformatf("rand %h", x), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
